icache_s2_nway: RTL

Parametrised second stage of the instruction cache: N-way set-associative tag compare, tree-PLRU replacement, cached line refill and uncached single-word fetch. Sits between the s1 stage (which supplies translated address, per-way tag/valid and way data read in the previous cycle) and the AXI bridge. Adds over the 2-way stage: configurable ways/line size, real replacement state, refill write-back to tag/data RAMs, and a held-data handshake to the CPU.

---
 rtl/icache_s2_nway_if.sv | 51 +++++
 rtl/icache_s2_nway.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/icache_s2_nway_if.sv
// rtl/icache_s2_nway_if.sv - s1 / AXI bridge / CPU facing signal bundle for icache_s2_nway
// slave = cache side, master = surrounding pipeline and bridge.
interface icache_s2_nway_if #(
  parameter int WAYS       = 2,
  parameter int LINE_WORDS = 8,
  parameter int SETS       = 128,
  parameter int TAG_W      = 20
);
  localparam int IDX_W = $clog2(SETS);

  logic                    req_i;
  logic [31:0]             paddr_i;
  logic                    cached_i;
  logic [WAYS*TAG_W-1:0]   tag_i;
  logic [WAYS-1:0]         valid_i;
  logic [WAYS*32-1:0]      data_i;
  logic                    flush_i;
  logic                    axi_req_o;
  logic [31:0]             axi_addr_o;
  logic                    uc_req_o;
  logic [31:0]             uc_addr_o;
  logic                    axi_ack_i;
  logic                    rend_i;
  logic [LINE_WORDS*32-1:0] rline_i;
  logic                    wr_en_o;
  logic [WAYS-1:0]         wr_way_o;
  logic [IDX_W-1:0]        wr_index_o;
  logic [TAG_W-1:0]        wr_tag_o;
  logic [LINE_WORDS*32-1:0] wr_line_o;
  logic                    stall_o;
  logic [WAYS-1:0]         hit_way_o;
  logic [31:0]             rdata_o;
  logic                    rvalid_o;
  logic                    cpu_ready_i;

  modport slave (
    input  req_i, paddr_i, cached_i, tag_i, valid_i, data_i, flush_i,
           axi_ack_i, rend_i, rline_i, cpu_ready_i,
    output axi_req_o, axi_addr_o, uc_req_o, uc_addr_o,
           wr_en_o, wr_way_o, wr_index_o, wr_tag_o, wr_line_o,
           stall_o, hit_way_o, rdata_o, rvalid_o
  );

  modport master (
    output req_i, paddr_i, cached_i, tag_i, valid_i, data_i, flush_i,
           axi_ack_i, rend_i, rline_i, cpu_ready_i,
    input  axi_req_o, axi_addr_o, uc_req_o, uc_addr_o,
           wr_en_o, wr_way_o, wr_index_o, wr_tag_o, wr_line_o,
           stall_o, hit_way_o, rdata_o, rvalid_o
  );
endinterface

// File: rtl/icache_s2_nway.sv
// rtl/icache_s2_nway.sv - icache stage 2: N-way tag compare, tree-PLRU, line refill, uncached fetch
// Way indices are carried as 2 bits and PLRU as 3 bits per set so WAYS=2 and WAYS=4 share one datapath.
module icache_s2_nway #(
  parameter int WAYS       = 2,
  parameter int LINE_WORDS = 8,
  parameter int SETS       = 128,
  parameter int TAG_W      = 20
) (
  input logic             clk,
  input logic             rst_n,
  icache_s2_nway_if.slave bus
);
  localparam int WOFF_W = $clog2(LINE_WORDS);
  localparam int OFF    = WOFF_W + 2;
  localparam int IDX_W  = $clog2(SETS);

  typedef enum logic [2:0] {IDLE, MISS, REFILL, UNCACHED, UC_WAIT, HOLD} state_t;

  state_t                    r_state, w_next;
  logic [31:0]               r_paddr;
  logic [1:0]                r_victim;
  logic [31:0]               r_word;
  logic                      r_wr_en;
  logic [LINE_WORDS*32-1:0]  r_line;
  logic [2:0]                r_plru [SETS];

  logic [TAG_W-1:0]  w_tag;
  logic [IDX_W-1:0]  w_idx, w_r_idx;
  logic [WAYS-1:0]   w_match;
  logic              w_any_hit, w_any_inv, w_lookup, w_hit;
  logic [1:0]        w_hit_idx, w_inv_idx, w_victim;
  logic [31:0]       w_hit_data, w_rdata;
  logic [WOFF_W+4:0] w_word_base;
  logic              w_latch_miss, w_latch_uc, w_fill_done, w_uc_done;
  logic              w_axi_req, w_uc_req, w_rvalid, w_stall;

  function automatic logic [WAYS-1:0] to_onehot(input logic [1:0] idx);
    logic [WAYS-1:0] oh;
    oh = '0;
    for (int w = 0; w < WAYS; w++) oh[w] = (idx == 2'(w));
    return oh;
  endfunction

  // 2 ways: bit0 names the way to replace. 4 ways: bit0 = root (1 -> ways 2/3),
  // bit1 = leaf of ways 0/1, bit2 = leaf of ways 2/3.
  function automatic logic [1:0] plru_victim(input logic [2:0] p);
    if (WAYS == 2) return {1'b0, p[0]};
    return p[0] ? {1'b1, p[2]} : {1'b0, p[1]};
  endfunction

  function automatic logic [2:0] plru_touch(input logic [2:0] p, input logic [1:0] idx);
    logic [2:0] n;
    n = p;
    if (WAYS == 2) begin
      n = {2'b00, ~idx[0]};
    end else begin
      n[0] = ~idx[1];
      if (idx[1]) n[2] = ~idx[0];
      else        n[1] = ~idx[0];
    end
    return n;
  endfunction

  assign w_tag       = bus.paddr_i[31 -: TAG_W];
  assign w_idx       = bus.paddr_i[OFF +: IDX_W];
  assign w_r_idx     = r_paddr[OFF +: IDX_W];
  assign w_word_base = {r_paddr[OFF-1:2], 5'd0};
  assign w_lookup    = bus.req_i & bus.cached_i & (r_state == IDLE);

  // Descending scan so the lowest matching / invalid way is the one kept.
  always_comb begin
    w_match   = '0;
    w_any_hit = 1'b0;
    w_hit_idx = '0;
    w_any_inv = 1'b0;
    w_inv_idx = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      w_match[w] = bus.valid_i[w] & (bus.tag_i[w*TAG_W +: TAG_W] == w_tag);
      if (w_match[w]) begin
        w_any_hit = 1'b1;
        w_hit_idx = 2'(w);
      end
      if (!bus.valid_i[w]) begin
        w_any_inv = 1'b1;
        w_inv_idx = 2'(w);
      end
    end
  end

  assign w_hit      = w_lookup & w_any_hit;
  assign w_hit_data = bus.data_i[{w_hit_idx, 5'd0} +: 32];
  assign w_victim   = w_any_inv ? w_inv_idx : plru_victim(r_plru[w_idx]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_axi_req    = 1'b0;
    w_uc_req     = 1'b0;
    w_rvalid     = 1'b0;
    w_rdata      = '0;
    w_stall      = 1'b1;
    w_latch_miss = 1'b0;
    w_latch_uc   = 1'b0;
    w_fill_done  = 1'b0;
    w_uc_done    = 1'b0;
    case (r_state)
      IDLE: begin
        w_stall = 1'b0;
        if (bus.req_i) begin
          if (!bus.cached_i) begin
            w_stall    = 1'b1;
            w_latch_uc = 1'b1;
            w_next     = UNCACHED;
          end else if (w_any_hit) begin
            w_rvalid = 1'b1;
            w_rdata  = w_hit_data;
          end else begin
            w_stall      = 1'b1;
            w_latch_miss = 1'b1;
            w_next       = MISS;
          end
        end
      end
      MISS: begin
        w_axi_req = 1'b1;
        if (bus.axi_ack_i) begin
          w_fill_done = bus.rend_i;
          w_next      = bus.rend_i ? HOLD : REFILL;
        end
      end
      REFILL: begin
        if (bus.rend_i) begin
          w_fill_done = 1'b1;
          w_next      = HOLD;
        end
      end
      UNCACHED: begin
        w_uc_req = 1'b1;
        if (bus.axi_ack_i) begin
          w_uc_done = bus.rend_i;
          w_next    = bus.rend_i ? HOLD : UC_WAIT;
        end
      end
      UC_WAIT: begin
        if (bus.rend_i) begin
          w_uc_done = 1'b1;
          w_next    = HOLD;
        end
      end
      HOLD: begin
        w_rvalid = 1'b1;
        w_rdata  = r_word;
        if (bus.cpu_ready_i) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_paddr  <= '0;
      r_victim <= '0;
      r_word   <= '0;
      r_wr_en  <= 1'b0;
      r_line   <= '0;
    end else begin
      r_wr_en <= w_fill_done;
      if (w_latch_miss | w_latch_uc) r_paddr  <= bus.paddr_i;
      if (w_latch_miss)              r_victim <= w_victim;
      if (w_fill_done) begin
        r_line <= bus.rline_i;
        r_word <= bus.rline_i[w_word_base +: 32];
      end else if (w_uc_done) begin
        r_word <= bus.rline_i[31:0];
      end
    end
  end

  // Flush takes priority over any replacement update landing on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) r_plru[s] <= '0;
    end else if (bus.flush_i) begin
      for (int s = 0; s < SETS; s++) r_plru[s] <= '0;
    end else if (w_hit) begin
      r_plru[w_idx] <= plru_touch(r_plru[w_idx], w_hit_idx);
    end else if (w_fill_done) begin
      r_plru[w_r_idx] <= plru_touch(r_plru[w_r_idx], r_victim);
    end
  end

  assign bus.axi_req_o  = w_axi_req;
  assign bus.axi_addr_o = w_axi_req ? {r_paddr[31:OFF], {OFF{1'b0}}} : '0;
  assign bus.uc_req_o   = w_uc_req;
  assign bus.uc_addr_o  = w_uc_req ? r_paddr : '0;
  assign bus.wr_en_o    = r_wr_en;
  assign bus.wr_way_o   = r_wr_en ? to_onehot(r_victim) : '0;
  assign bus.wr_index_o = r_wr_en ? w_r_idx : '0;
  assign bus.wr_tag_o   = r_wr_en ? r_paddr[31 -: TAG_W] : '0;
  assign bus.wr_line_o  = r_wr_en ? r_line : '0;
  assign bus.stall_o    = w_stall;
  assign bus.hit_way_o  = w_hit ? to_onehot(w_hit_idx) : '0;
  assign bus.rdata_o    = w_rdata;
  assign bus.rvalid_o   = w_rvalid;
endmodule
